// File: rtl/sr_drive_pkg.sv
// Shared types and parameter defaults for the SR latch drive controller.
package sr_drive_pkg;

   // Controller states: idle, drive set, drive reset, dead time after a pulse
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE_S = 2'd1,
      PULSE_R = 2'd2,
      HOLD    = 2'd3
   } sr_state_e;

   localparam int DEB_CYC_DEF  = 4;
   localparam int PULSE_W_DEF  = 2;
   localparam int HOLD_CYC_DEF = 2;

   // Counter widths sized for the legal parameter ranges (DEB_CYC <= 255, others <= 15)
   localparam int DEB_CNT_W = 8;
   localparam int PH_CNT_W  = 4;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one raw input.
module sr_debounce
   import sr_drive_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o
);

   localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYC - 1);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 level_q;
   logic                 level_d;
   logic [DEB_CNT_W-1:0] cnt_q;
   logic [DEB_CNT_W-1:0] cnt_d;

   // Bring the raw asynchronous input into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts the count
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Hold the debounced level and its qualification counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// SR latch drive controller: debounces set/reset requests and issues fixed-width,
// mutually exclusive set/reset pulses with a dead time between them.
// Optional feature macro: SR_DRIVE_CTRL_CONFLICT_EN adds a sticky 'conflict' output.
module sr_drive_ctrl
   import sr_drive_pkg::*;
#(
   parameter int DEB_CYC  = DEB_CYC_DEF,
   parameter int PULSE_W  = PULSE_W_DEF,
   parameter int HOLD_CYC = HOLD_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_req,
   input  logic rst_req,
   output logic s,
   output logic r,
   output logic s_n,
   output logic r_n,
   output logic q_exp,
   output logic busy
`ifdef SR_DRIVE_CTRL_CONFLICT_EN
   ,
   output logic conflict
`endif
);

   localparam logic [PH_CNT_W-1:0] PW_LAST   = PH_CNT_W'(PULSE_W - 1);
   localparam logic [PH_CNT_W-1:0] HOLD_LAST = PH_CNT_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

   // Index 0 is the set path, index 1 the reset path
   logic [1:0] raw_w;
   logic [1:0] level_w;
   logic [1:0] level_dly_q;
   logic [1:0] ev_q;

   sr_state_e             state_q;
   logic [PH_CNT_W-1:0]   cnt_q;
   logic                  pend_s_q;
   logic                  pend_r_q;
   logic                  s_q;
   logic                  r_q;
   logic                  s_n_q;
   logic                  r_n_q;
   logic                  q_exp_q;
   logic                  busy_q;

   assign raw_w = {rst_req, set_req};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_deb
         sr_debounce #(
            .DEB_CYC (DEB_CYC)
         ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (raw_w[gi]),
            .level_o (level_w[gi])
         );
      end
   endgenerate

   // Registered one-cycle event on each rising debounced level (falling edges are ignored)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_dly_q <= 2'b00;
         ev_q        <= 2'b00;
      end else begin
         level_dly_q <= level_w;
         ev_q        <= level_w & ~level_dly_q;
      end
   end

   // Pulse sequencer; requests seen while busy are parked (one per input) and served from IDLE on the next edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pend_s_q <= 1'b0;
         pend_r_q <= 1'b0;
         s_q      <= 1'b0;
         r_q      <= 1'b0;
         s_n_q    <= 1'b1;
         r_n_q    <= 1'b1;
         q_exp_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         if (state_q != IDLE) begin
            pend_s_q <= pend_s_q | ev_q[0];
            pend_r_q <= pend_r_q | ev_q[1];
         end
         case (state_q)
            IDLE: begin
               // Reset has priority; a competing set request is discarded
               if (ev_q[1] || pend_r_q) begin
                  state_q  <= PULSE_R;
                  r_q      <= 1'b1;
                  r_n_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  pend_s_q <= 1'b0;
                  pend_r_q <= 1'b0;
               end else if (ev_q[0] || pend_s_q) begin
                  state_q  <= PULSE_S;
                  s_q      <= 1'b1;
                  s_n_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  pend_s_q <= 1'b0;
                  pend_r_q <= 1'b0;
               end
            end
            PULSE_S, PULSE_R: begin
               if (cnt_q == PW_LAST) begin
                  s_q     <= 1'b0;
                  r_q     <= 1'b0;
                  s_n_q   <= 1'b1;
                  r_n_q   <= 1'b1;
                  q_exp_q <= (state_q == PULSE_S);
                  cnt_q   <= '0;
                  if (HOLD_CYC == 0) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= HOLD;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s     = s_q;
   assign r     = r_q;
   assign s_n   = s_n_q;
   assign r_n   = r_n_q;
   assign q_exp = q_exp_q;
   assign busy  = busy_q;

`ifdef SR_DRIVE_CTRL_CONFLICT_EN
   logic conflict_q;

   // Sticky flag for any cycle where both debounced requests are high together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_q <= 1'b0;
      end else begin
         conflict_q <= conflict_q | (&level_w);
      end
   end

   assign conflict = conflict_q;
`else
   // Conflict tracking is not built in this configuration
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Self-checking bench for sr_drive_ctrl: directed table, hand-written corner sequences,
// and randomized stimulus compared every cycle against a timestamp-based reference model.
module tb_sr_drive_ctrl;

   localparam int DEB  = 4;
   localparam int PW   = 2;
   localparam int HOLD = 2;

   logic clk;
   logic rst_n;
   logic set_req;
   logic rst_req;
   logic s, r, s_n, r_n, q_exp, busy;
`ifdef SR_DRIVE_CTRL_CONFLICT_EN
   logic conflict;
`endif

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   sr_drive_ctrl #(
      .DEB_CYC  (DEB),
      .PULSE_W  (PW),
      .HOLD_CYC (HOLD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_req (set_req),
      .rst_req (rst_req),
      .s       (s),
      .r       (r),
      .s_n     (s_n),
      .r_n     (r_n),
      .q_exp   (q_exp),
      .busy    (busy)
`ifdef SR_DRIVE_CTRL_CONFLICT_EN
      ,
      .conflict(conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] mk(bit s_e, bit r_e, bit q_e, bit b_e);
      return {s_e, r_e, ~s_e, ~r_e, q_e, b_e};
   endfunction

   function automatic logic [5:0] outs();
      return {s, r, s_n, r_n, q_exp, busy};
   endfunction

   task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s t=%0t: got {s,r,s_n,r_n,q,busy}=%b expected %b", nm, $time, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   // Edge m_e counts clk edges since reset release. A raw level sampled at edge k reaches the
   // debouncer at edge k+2; a level rise accepted at edge m is acted on by the sequencer at m+2.
   // A job started at edge t drives its output for edges t..t+PW-1, updates q at t+PW and the
   // controller is idle again from edge t+PW+HOLD; decisions are taken on the edge after that.
   int m_e;
   bit hs[$];
   bit hr[$];
   int lvl[2], run[2], ev_at[2];
   bit pend[2];
   int job_t, job_k, idle_from;
   bit exp_s, exp_r, exp_q, exp_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_e = 0;
         hs.delete();
         hr.delete();
         for (int i = 0; i < 2; i++) begin
            lvl[i] = 0; run[i] = 0; ev_at[i] = -100; pend[i] = 0;
         end
         job_t = 0; job_k = 0; idle_from = -1;
         exp_s = 0; exp_r = 0; exp_q = 0; exp_busy = 0;
      end else begin
         bit evs, evr, x;
         evs = (ev_at[0] == m_e);
         evr = (ev_at[1] == m_e);
         if (m_e > idle_from) begin
            if (evr || pend[1]) begin
               job_t = m_e; job_k = 2; idle_from = m_e + PW + HOLD;
            end else if (evs || pend[0]) begin
               job_t = m_e; job_k = 1; idle_from = m_e + PW + HOLD;
            end
            pend[0] = 0;
            pend[1] = 0;
         end else begin
            pend[0] = pend[0] | evs;
            pend[1] = pend[1] | evr;
         end
         if (job_k != 0 && m_e == job_t + PW) exp_q = (job_k == 1);
         exp_s    = (job_k == 1) && (m_e >= job_t) && (m_e < job_t + PW);
         exp_r    = (job_k == 2) && (m_e >= job_t) && (m_e < job_t + PW);
         exp_busy = (job_k != 0) && (m_e < idle_from);
         hs.push_back(set_req);
         hr.push_back(rst_req);
         for (int i = 0; i < 2; i++) begin
            if (m_e >= 2) x = (i == 0) ? hs[m_e-2] : hr[m_e-2];
            else          x = 0;
            if (int'(x) != lvl[i]) begin
               run[i]++;
               if (run[i] == DEB) begin
                  lvl[i] = x;
                  run[i] = 0;
                  if (x) ev_at[i] = m_e + 2;
               end
            end else begin
               run[i] = 0;
            end
         end
         m_e++;
      end
   end

   // Every cycle, compare DUT outputs with the model
   always @(negedge clk) begin
      if (chk_en) chk("model", outs(), mk(exp_s, exp_r, exp_q, exp_busy));
   end

   // ---------------- directed table ----------------
   typedef struct {
      bit         set_v;
      bit         rst_v;
      int         ncyc;
      logic [3:0] exp;   // {s, r, q_exp, busy}
   } vec_t;

   vec_t tbl[14];

   initial begin
      // set held from cycle 0: s at 7-8, q from 9, idle at 11; falling level does nothing
      tbl[0]  = '{1'b1, 1'b0, 7,  4'b0000};
      tbl[1]  = '{1'b1, 1'b0, 1,  4'b1001};
      tbl[2]  = '{1'b1, 1'b0, 1,  4'b1001};
      tbl[3]  = '{1'b1, 1'b0, 1,  4'b0011};
      tbl[4]  = '{1'b1, 1'b0, 1,  4'b0011};
      tbl[5]  = '{1'b1, 1'b0, 1,  4'b0010};
      tbl[6]  = '{1'b0, 1'b0, 10, 4'b0010};
      // set and reset together with q=1: only r pulses, set discarded
      tbl[7]  = '{1'b1, 1'b1, 7,  4'b0010};
      tbl[8]  = '{1'b1, 1'b1, 1,  4'b0111};
      tbl[9]  = '{1'b1, 1'b1, 1,  4'b0111};
      tbl[10] = '{1'b1, 1'b1, 1,  4'b0001};
      tbl[11] = '{1'b1, 1'b1, 2,  4'b0000};
      tbl[12] = '{1'b1, 1'b1, 10, 4'b0000};
      tbl[13] = '{1'b0, 1'b0, 10, 4'b0000};

      rst_n = 1'b0; set_req = 1'b0; rst_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_state", outs(), mk(0, 0, 0, 0));
      chk_en = 1'b1;
      rst_n  = 1'b1;

      for (int i = 0; i < 14; i++) begin
         set_req = tbl[i].set_v;
         rst_req = tbl[i].rst_v;
         repeat (tbl[i].ncyc) tick();
         chk($sformatf("table[%0d]", i), outs(), mk(tbl[i].exp[3], tbl[i].exp[2], tbl[i].exp[1], tbl[i].exp[0]));
      end

      // Bouncy set toggling every 2 cycles never qualifies
      for (int c = 0; c < 20; c++) begin
         set_req = ((c / 2) % 2 == 0);
         tick();
         chk("bounce", outs(), mk(0, 0, 0, 0));
      end
      set_req = 1'b0;
      repeat (8) tick();
      chk("bounce_end", outs(), mk(0, 0, 0, 0));

      // Reset event lands during PULSE_S: served after HOLD, never overlapping s
      set_req = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         tick();
         if (c == 0) rst_req = 1'b1;
         chk($sformatf("rst_in_pulse_c%0d", c), outs(),
             mk(c == 7 || c == 8, c == 12 || c == 13, c >= 9 && c < 14,
                (c >= 7 && c <= 10) || (c >= 12 && c <= 15)));
      end
      set_req = 1'b0; rst_req = 1'b0;
      repeat (12) tick();

      // Reset asserted in the middle of PULSE_S, then requalification
      set_req = 1'b1;
      repeat (8) tick();
      chk("pre_abort", outs(), mk(1, 0, 0, 1));
      #1 rst_n = 1'b0;
      #1 chk("abort", outs(), mk(0, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c <= 9; c++) begin
         tick();
         chk($sformatf("requal_c%0d", c), outs(), mk(c == 7 || c == 8, 0, c >= 9, c >= 7));
      end
      set_req = 1'b0;
      repeat (12) tick();

`ifdef SR_DRIVE_CTRL_CONFLICT_EN
      // Sticky conflict flag
      #2 rst_n = 1'b0;
      #1 chk("conflict_rst", {5'b0, conflict}, 6'd0);
      tick();
      rst_n = 1'b1;
      set_req = 1'b1; rst_req = 1'b1;
      repeat (12) tick();
      chk("conflict_set", {5'b0, conflict}, 6'd1);
      set_req = 1'b0; rst_req = 1'b0;
      repeat (12) tick();
      chk("conflict_sticky", {5'b0, conflict}, 6'd1);
      #2 rst_n = 1'b0;
      #1 chk("conflict_clr", {5'b0, conflict}, 6'd0);
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
`endif

      // Randomized requests with occasional resets; the model checker runs every cycle
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 6) == 0) set_req = ~set_req;
         if ($urandom_range(0, 6) == 0) rst_req = ~rst_req;
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      set_req = 1'b0; rst_req = 1'b0;
      repeat (20) tick();
      chk("final_idle", {s, r, s_n, r_n, 1'b0, busy}, mk(0, 0, 0, 0));

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYC, default 4, meaning consecutive stable synchronized samples needed to accept an input level change (legal range 1..255).
REQ-002 SHALL have parameter PULSE_W, default 2, meaning width in cycles of each set/reset drive pulse (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 2, meaning dead cycles after a pulse before another pulse may start (legal range 0..15).
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port set_req  input  1  raw, asynchronous, bouncy set request (rising level = request).
REQ-007 SHALL have port rst_req  input  1  raw, asynchronous, bouncy reset request.
REQ-008 SHALL have port s  output  1  active-high set drive for a NOR-based SR latch.
REQ-009 SHALL have port r  output  1  active-high reset drive for a NOR-based SR latch.
REQ-010 SHALL have port s_n  output  1  active-low set drive for a NAND-based SR latch; always equals ~s.
REQ-011 SHALL have port r_n  output  1  active-low reset drive for a NAND-based SR latch; always equals ~r.
REQ-012 SHALL have port q_exp  output  1  expected latch state after the last completed pulse.
REQ-013 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-014 SHALL pass each raw input through its own two-flop synchronizer before any other use.
REQ-015 SHALL keep one debounced level per input, changing it only after DEB_CYC consecutive synchronized samples differ from it; any agreeing sample clears that input's counter.
REQ-016 SHALL generate a one-cycle event on each 0->1 transition of a debounced level; 1->0 transitions generate nothing.
REQ-017 SHALL implement FSM states IDLE, PULSE_S, PULSE_R, HOLD.
REQ-018 SHALL move IDLE->PULSE_R on a reset event, else IDLE->PULSE_S on a set event; a simultaneous set and reset event SHALL select PULSE_R (reset wins) and discard the set event.
REQ-019 SHALL assert s only in PULSE_S and r only in PULSE_R, each for exactly PULSE_W cycles; s and r SHALL never be high in the same cycle.
REQ-020 SHALL update q_exp to 1 at the exit of PULSE_S and to 0 at the exit of PULSE_R, then enter HOLD for HOLD_CYC cycles, or go straight to IDLE when HOLD_CYC=0.
REQ-021 SHALL latch at most one event per input that arrives while busy, and serve it on return to IDLE with reset priority; further events of the same input while one is pending SHALL be dropped.
REQ-022 SHALL assert s exactly DEB_CYC+3 cycles after the first clk edge that samples a stable raw high on set_req from IDLE; the same latency SHALL apply to r.
REQ-023 SHALL register all outputs so they are glitch-free.

Reset
REQ-024 SHALL, while rst_n=0, force s=0, r=0, s_n=1, r_n=1, q_exp=0, busy=0, state IDLE, all synchronizers, debounced levels, counters and pending flags to 0.
REQ-025 SHALL abort any pulse in progress immediately on rst_n assertion, leave q_exp at 0, and take no action from inputs until deassertion plus the REQ-022 latency.

Configuration
REQ-026 SHALL support macro SR_DRIVE_CTRL_CONFLICT_EN; when defined, add output conflict (1 bit, reset 0), set sticky for any cycle in which both debounced levels are 1 and cleared only by reset; when undefined, the port and its logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-027 SHALL place the FSM state enumerated type and the default values of DEB_CYC, PULSE_W and HOLD_CYC in shared package sr_drive_pkg.
REQ-028 SHALL implement synchronizer plus debouncer as sub-module sr_debounce, instantiated once per input.

Verification
REQ-029 SHALL cover: set_req held at 1 from cycle 0 (DEB_CYC=4, PULSE_W=2) -> s=1, s_n=0 at cycles 7-8, q_exp=1 from cycle 9, busy low at cycle 11.
REQ-030 SHALL cover: set_req toggling every 2 cycles for 20 cycles -> s never asserts, q_exp stays 0.
REQ-031 SHALL cover: set_req and rst_req rising on the same edge with q_exp=1 -> only r pulses for 2 cycles, q_exp=0, no s pulse follows.
REQ-032 SHALL cover: rst_req event arriving during PULSE_S -> r pulse starts in the first IDLE cycle after HOLD; s and r never overlap.
REQ-033 SHALL cover: rst_n driven low in the middle of a PULSE_S -> s=0, q_exp=0 in the same cycle; no pulse after release until the inputs re-qualify.
REQ-034 SHALL cover, with SR_DRIVE_CTRL_CONFLICT_EN defined: both inputs held high -> conflict=1 and stays 1 after both drop, until rst_n=0.
